// File: rtl/serv_bus_pkg.sv
// Shared types for the SERV bus arbiter: FSM states, grant encoding and
// the priority pick used when both buses request together.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } grant_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // On contention the bus that did not win last time gets the grant
  function automatic grant_e pick_grant(input logic ibus_cyc, input logic dbus_cyc,
                                        input grant_e last);
    grant_e g;
    if (ibus_cyc && dbus_cyc) begin
      g = (last == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
    end else if (dbus_cyc) begin
      g = GNT_DBUS;
    end else begin
      g = GNT_IBUS;
    end
    return g;
  endfunction

endpackage

// File: rtl/serv_bus_arbiter_if.sv
// Request, response and shared Wishbone signals of the arbiter. The slave
// modport is the arbiter's view; the master modport is the core/memory side.
interface serv_bus_arbiter_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_timeout;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
           i_dbus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr, o_wb_dat,
           o_wb_sel, o_wb_we, o_wb_cyc, o_timeout
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
           i_dbus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr, o_wb_dat,
           o_wb_sel, o_wb_we, o_wb_cyc, o_timeout
  );
endinterface

// File: rtl/serv_bus_watchdog.sv
// Saturating cycle counter that flags expiry on the TIMEOUT-th enabled cycle.
// TIMEOUT = 0 disables expiry entirely.
module serv_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int unsigned CW    = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam int unsigned LIM   = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  localparam logic [CW-1:0] LIMIT = CW'(LIM);
  localparam logic [CW-1:0] MAX   = {CW{1'b1}};
  localparam bit ACTIVE = (TIMEOUT != 32'd0);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles, hold at all-ones rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != MAX)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = ACTIVE && en && (cnt_r == LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master port between the SERV ibus and dbus; one
// transfer at a time, alternating priority, with a watchdog against hung slaves.
module serv_bus_arbiter
  import serv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              i_rst_n,
  serv_bus_arbiter_if.slave bus
);

  state_e      state_r, state_s;
  grant_e      grant_r, grant_s;
  grant_e      last_grant_r, last_grant_s;
  logic [31:0] wb_adr_r, wb_adr_s;
  logic [31:0] wb_dat_r, wb_dat_s;
  logic [3:0]  wb_sel_r, wb_sel_s;
  logic        wb_we_r, wb_we_s;
  logic        wb_cyc_r, wb_cyc_s;
  logic [31:0] ibus_rdt_r, ibus_rdt_s;
  logic [31:0] dbus_rdt_r, dbus_rdt_s;
  logic        ibus_ack_r, ibus_ack_s;
  logic        dbus_ack_r, dbus_ack_s;
  logic        timeout_r, timeout_s;
  logic        req_cyc_s;
  logic        expire_s;
  logic        busy_s;

  assign busy_s = (state_r == BUSY);

  serv_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .en     (busy_s),
    .clr    (!busy_s),
    .expire (expire_s)
  );

  // Next-state and next-output logic; everything holds unless a branch changes it
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    wb_adr_s     = wb_adr_r;
    wb_dat_s     = wb_dat_r;
    wb_sel_s     = wb_sel_r;
    wb_we_s      = wb_we_r;
    wb_cyc_s     = wb_cyc_r;
    ibus_rdt_s   = ibus_rdt_r;
    dbus_rdt_s   = dbus_rdt_r;
    ibus_ack_s   = 1'b0;
    dbus_ack_s   = 1'b0;
    timeout_s    = 1'b0;
    req_cyc_s    = (grant_r == GNT_DBUS) ? bus.i_dbus_cyc : bus.i_ibus_cyc;

    case (state_r)
      IDLE: begin
        if (bus.i_ibus_cyc || bus.i_dbus_cyc) begin
          grant_s      = pick_grant(bus.i_ibus_cyc, bus.i_dbus_cyc, last_grant_r);
          last_grant_s = grant_s;
          wb_cyc_s     = 1'b1;
          state_s      = BUSY;
          if (grant_s == GNT_DBUS) begin
            wb_adr_s = bus.i_dbus_adr;
            wb_dat_s = bus.i_dbus_dat;
            wb_sel_s = bus.i_dbus_sel;
            wb_we_s  = bus.i_dbus_we;
          end else begin
            wb_adr_s = bus.i_ibus_adr;
            wb_dat_s = 32'h0000_0000;
            wb_sel_s = SEL_ALL;
            wb_we_s  = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Slave ack takes precedence over both abort and watchdog expiry
        if (bus.i_wb_ack) begin
          wb_cyc_s = 1'b0;
          state_s  = RESP;
          if (grant_r == GNT_DBUS) begin
            dbus_rdt_s = bus.i_wb_rdt;
            dbus_ack_s = 1'b1;
          end else begin
            ibus_rdt_s = bus.i_wb_rdt;
            ibus_ack_s = 1'b1;
          end
        end else if (!req_cyc_s) begin
          wb_cyc_s = 1'b0;
          state_s  = IDLE;
        end else if (expire_s) begin
          wb_cyc_s  = 1'b0;
          timeout_s = 1'b1;
          state_s   = RESP;
          if (grant_r == GNT_DBUS) begin
            dbus_rdt_s = 32'h0000_0000;
            dbus_ack_s = 1'b1;
          end else begin
            ibus_rdt_s = 32'h0000_0000;
            ibus_ack_s = 1'b1;
          end
        end else begin
          state_s = BUSY;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s  = IDLE;
        wb_cyc_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus cycle without an ack
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      grant_r      <= GNT_IBUS;
      last_grant_r <= GNT_IBUS;
      wb_adr_r     <= 32'h0000_0000;
      wb_dat_r     <= 32'h0000_0000;
      wb_sel_r     <= 4'h0;
      wb_we_r      <= 1'b0;
      wb_cyc_r     <= 1'b0;
      ibus_rdt_r   <= 32'h0000_0000;
      dbus_rdt_r   <= 32'h0000_0000;
      ibus_ack_r   <= 1'b0;
      dbus_ack_r   <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      wb_adr_r     <= wb_adr_s;
      wb_dat_r     <= wb_dat_s;
      wb_sel_r     <= wb_sel_s;
      wb_we_r      <= wb_we_s;
      wb_cyc_r     <= wb_cyc_s;
      ibus_rdt_r   <= ibus_rdt_s;
      dbus_rdt_r   <= dbus_rdt_s;
      ibus_ack_r   <= ibus_ack_s;
      dbus_ack_r   <= dbus_ack_s;
      timeout_r    <= timeout_s;
    end
  end

  assign bus.o_wb_adr   = wb_adr_r;
  assign bus.o_wb_dat   = wb_dat_r;
  assign bus.o_wb_sel   = wb_sel_r;
  assign bus.o_wb_we    = wb_we_r;
  assign bus.o_wb_cyc   = wb_cyc_r;
  assign bus.o_ibus_rdt = ibus_rdt_r;
  assign bus.o_ibus_ack = ibus_ack_r;
  assign bus.o_dbus_rdt = dbus_rdt_r;
  assign bus.o_dbus_ack = dbus_ack_r;
  assign bus.o_timeout  = timeout_r;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter (TIMEOUT = 8) with hand-computed
// expected values; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_serv_bus_arbiter;
  logic clk;
  logic i_rst_n;
  int   n_cmp;
  int   n_err;

  serv_bus_arbiter_if bus ();

  serv_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_ack(input logic [31:0] rdt);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = rdt;
    tick();
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rdt = 32'h0;
  endtask

  task automatic set_dbus(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we);
    bus.i_dbus_adr = adr;
    bus.i_dbus_dat = dat;
    bus.i_dbus_sel = sel;
    bus.i_dbus_we  = we;
    bus.i_dbus_cyc = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    i_rst_n = 1'b0;
    bus.i_ibus_adr = 32'h0; bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = 32'h0; bus.i_dbus_dat = 32'h0; bus.i_dbus_sel = 4'h0;
    bus.i_dbus_we = 1'b0;   bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt = 32'h0;   bus.i_wb_ack = 1'b0;
    #12;
    check_eq("rst_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
    check_eq("rst_adr", bus.o_wb_adr, 32'h0);
    check_eq("rst_acks", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd0);
    check_eq("rst_to", {31'd0, bus.o_timeout}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();

    // ibus-only read
    bus.i_ibus_adr = 32'h100; bus.i_ibus_cyc = 1'b1;
    tick();
    check_eq("ib_cyc", {31'd0, bus.o_wb_cyc}, 32'd1);
    check_eq("ib_adr", bus.o_wb_adr, 32'h100);
    check_eq("ib_sel_we", {27'd0, bus.o_wb_sel, bus.o_wb_we}, {27'd0, 4'hF, 1'b0});
    check_eq("ib_dat", bus.o_wb_dat, 32'h0);
    slave_ack(32'hDEADBEEF);
    check_eq("ib_ack", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd2);
    check_eq("ib_rdt", bus.o_ibus_rdt, 32'hDEADBEEF);
    check_eq("ib_cyc_drop", {31'd0, bus.o_wb_cyc}, 32'd0);
    bus.i_ibus_cyc = 1'b0;
    tick();
    check_eq("ib_ack_1cyc", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd0);
    check_eq("ib_rdt_hold", bus.o_ibus_rdt, 32'hDEADBEEF);

    // dbus store; cyc held through RESP must not be re-granted there
    set_dbus(32'h2004, 32'h12345678, 4'b0011, 1'b1);
    tick();
    check_eq("db_adr", bus.o_wb_adr, 32'h2004);
    check_eq("db_dat", bus.o_wb_dat, 32'h12345678);
    check_eq("db_sel_we_cyc", {26'd0, bus.o_wb_sel, bus.o_wb_we, bus.o_wb_cyc}, {26'd0, 4'b0011, 1'b1, 1'b1});
    slave_ack(32'hCAFEF00D);
    check_eq("db_ack", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd1);
    check_eq("db_rdt", bus.o_dbus_rdt, 32'hCAFEF00D);
    check_eq("db_ib_rdt_untouched", bus.o_ibus_rdt, 32'hDEADBEEF);
    tick();
    check_eq("db_no_regrant", {31'd0, bus.o_wb_cyc}, 32'd0);
    check_eq("db_ack_1cyc", {31'd0, bus.o_dbus_ack}, 32'd0);
    bus.i_dbus_cyc = 1'b0;
    tick();

    // Contention after reset: dbus first, then waiting ibus
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    bus.i_ibus_adr = 32'h300; bus.i_ibus_cyc = 1'b1;
    set_dbus(32'h400, 32'h0, 4'hF, 1'b0);
    tick();
    check_eq("ct1_dbus_first", bus.o_wb_adr, 32'h400);
    slave_ack(32'h1111);
    check_eq("ct1_dbus_ack", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd1);
    bus.i_dbus_cyc = 1'b0;
    tick();
    tick();
    check_eq("ct1_ibus_next", {bus.o_wb_adr[30:0], bus.o_wb_cyc}, {31'h300, 1'b1});
    slave_ack(32'h2222);
    check_eq("ct1_ibus_rdt", bus.o_ibus_rdt, 32'h2222);
    bus.i_ibus_cyc = 1'b0;
    tick();
    // dbus-only transfer leaves last grant at dbus, so the next pair goes to ibus
    set_dbus(32'h404, 32'h0, 4'hF, 1'b0);
    tick();
    slave_ack(32'h3333);
    bus.i_dbus_cyc = 1'b0;
    tick();
    bus.i_ibus_cyc = 1'b1; bus.i_ibus_adr = 32'h304;
    set_dbus(32'h408, 32'h0, 4'hF, 1'b0);
    tick();
    check_eq("ct2_ibus_first", bus.o_wb_adr, 32'h304);
    slave_ack(32'h4444);
    bus.i_ibus_cyc = 1'b0;
    tick();
    tick();
    check_eq("ct2_dbus_next", bus.o_wb_adr, 32'h408);
    slave_ack(32'h5555);
    check_eq("ct2_dbus_rdt", bus.o_dbus_rdt, 32'h5555);
    bus.i_dbus_cyc = 1'b0;
    tick();

    // Watchdog expiry: slave never acks
    bus.i_ibus_adr = 32'h500; bus.i_ibus_cyc = 1'b1;
    tick();
    check_eq("wd_cyc_rise", {31'd0, bus.o_wb_cyc}, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    check_eq("wd_still_busy", {29'd0, bus.o_wb_cyc, bus.o_ibus_ack, bus.o_timeout}, {29'd0, 3'b100});
    tick();
    check_eq("wd_fire", {29'd0, bus.o_wb_cyc, bus.o_ibus_ack, bus.o_timeout}, {29'd0, 3'b011});
    check_eq("wd_rdt_zero", bus.o_ibus_rdt, 32'h0);
    bus.i_ibus_cyc = 1'b0;
    tick();
    check_eq("wd_to_1cyc", {30'd0, bus.o_ibus_ack, bus.o_timeout}, 32'd0);

    // Ack in the final watchdog cycle beats expiry
    bus.i_ibus_adr = 32'h504; bus.i_ibus_cyc = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    slave_ack(32'hA5A5A5A5);
    check_eq("wd_ack_wins", {30'd0, bus.o_ibus_ack, bus.o_timeout}, 32'd2);
    check_eq("wd_ack_rdt", bus.o_ibus_rdt, 32'hA5A5A5A5);
    bus.i_ibus_cyc = 1'b0;
    tick();

    // Abort: requester drops cyc with no ack
    set_dbus(32'h700, 32'h77, 4'h1, 1'b1);
    tick();
    bus.i_dbus_cyc = 1'b0;
    tick();
    check_eq("abort_cyc", {30'd0, bus.o_wb_cyc, bus.o_dbus_ack}, 32'd0);
    check_eq("abort_rdt_hold", bus.o_dbus_rdt, 32'h5555);
    tick();

    // Async reset mid-BUSY, then pending dbus request re-granted
    set_dbus(32'h600, 32'h66, 4'hC, 1'b1);
    tick();
    check_eq("ar_busy", {31'd0, bus.o_wb_cyc}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("ar_drop", {28'd0, bus.o_wb_cyc, bus.o_ibus_ack, bus.o_dbus_ack, bus.o_timeout}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();
    check_eq("ar_regrant", {bus.o_wb_adr[30:0], bus.o_wb_cyc}, {31'h600, 1'b1});
    slave_ack(32'h6060);
    check_eq("ar_ack", {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd1);
    bus.i_dbus_cyc = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
